// File: rtl/axi_sram_slave.sv
// AXI3 slave endpoint with an internal word-addressed SRAM.
// Independent write (AW/W/B) and read (AR/R) state machines, one burst at a time each.
module axi_sram_slave #(
  parameter int MEM_WORDS = 1024,
  parameter int IDS_BITS  = 8
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [IDS_BITS-1:0] AWID,
  input  logic [31:0]         AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [31:0]         WDATA,
  input  logic [3:0]          WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [IDS_BITS-1:0] BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [IDS_BITS-1:0] ARID,
  input  logic [31:0]         ARADDR,
  input  logic [3:0]          ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [IDS_BITS-1:0] RID,
  output logic [31:0]         RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  logic [31:0] mem [MEM_WORDS];

  w_state_e            w_state_q, w_state_d;
  logic [IDS_BITS-1:0] w_id_q,    w_id_d;
  logic [AW-1:0]       w_idx_q,   w_idx_d;
  logic [3:0]          w_len_q,   w_len_d;
  logic [3:0]          w_cnt_q,   w_cnt_d;
  logic [1:0]          w_burst_q, w_burst_d;
  logic                w_err_q,   w_err_d;
  logic                mem_we;

  r_state_e            r_state_q, r_state_d;
  logic [IDS_BITS-1:0] r_id_q,    r_id_d;
  logic [AW-1:0]       r_idx_q,   r_idx_d;
  logic [3:0]          r_len_q,   r_len_d;
  logic [3:0]          r_cnt_q,   r_cnt_d;
  logic [1:0]          r_burst_q, r_burst_d;
  logic [31:0]         rdata_q,   rdata_d;

  logic awready, wready, bvalid, arready, rvalid, rlast;

  // Size and out-of-range address bits are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = ^{AWSIZE, ARSIZE, AWADDR[31:AW+2], AWADDR[1:0],
                           ARADDR[31:AW+2], ARADDR[1:0]};

  // Handshake outputs are gated by reset so they read idle during the reset cycle itself.
  assign awready = (w_state_q == W_IDLE) && !ARESET;
  assign wready  = (w_state_q == W_DATA) && !ARESET;
  assign bvalid  = (w_state_q == W_RESP) && !ARESET;
  assign arready = (r_state_q == R_IDLE) && !ARESET;
  assign rvalid  = (r_state_q == R_DATA) && !ARESET;
  assign rlast   = rvalid && (r_cnt_q == r_len_q);

  assign AWREADY = awready;
  assign WREADY  = wready;
  assign BVALID  = bvalid;
  assign BID     = bvalid ? w_id_q : '0;
  assign BRESP   = (bvalid && w_err_q) ? 2'b10 : 2'b00;
  assign ARREADY = arready;
  assign RVALID  = rvalid;
  assign RLAST   = rlast;
  assign RID     = rvalid ? r_id_q : '0;
  assign RDATA   = ARESET ? '0 : rdata_q;
  assign RRESP   = 2'b00;

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_burst_d = w_burst_q;
    w_err_d   = w_err_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (AWVALID && awready) begin
          w_id_d    = AWID;
          w_idx_d   = AWADDR[AW+1:2];
          w_len_d   = AWLEN;
          w_burst_d = AWBURST;
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (WVALID && wready) begin
          mem_we  = 1'b1;
          w_err_d = w_err_q | (WLAST != (w_cnt_q == w_len_q));
          if (w_cnt_q == w_len_q) begin
            w_state_d = W_RESP;
          end else begin
            w_cnt_d = w_cnt_q + 4'd1;
            if (w_burst_q != 2'b00) w_idx_d = w_idx_q + 1'b1;
          end
        end
      end
      W_RESP: begin
        if (BREADY && bvalid) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_burst_d = r_burst_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (ARVALID && arready) begin
          r_id_d    = ARID;
          r_idx_d   = ARADDR[AW+1:2];
          r_len_d   = ARLEN;
          r_burst_d = ARBURST;
          r_cnt_d   = '0;
          rdata_d   = mem[ARADDR[AW+1:2]];
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (RREADY && rvalid) begin
          if (rlast) begin
            r_state_d = R_IDLE;
          end else begin
            if (r_burst_q != 2'b00) r_idx_d = r_idx_q + 1'b1;
            rdata_d = mem[r_idx_d];
            r_cnt_d = r_cnt_q + 4'd1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_burst_q <= '0;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_burst_q <= r_burst_d;
      rdata_q   <= rdata_d;
    end
  end

  // Memory is not reset; a read-load in the same cycle as a write sees the old word.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (WSTRB[i]) mem[w_idx_q][8*i +: 8] <= WDATA[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed plus randomized bench for axi_sram_slave against a word-array reference model.
module tb_axi_sram_slave;

  localparam int MEM_WORDS = 1024;
  localparam int AW        = $clog2(MEM_WORDS);

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [7:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [7:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  axi_sram_slave #(.MEM_WORDS(MEM_WORDS), .IDS_BITS(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] wdata_a [16];
  logic [3:0]  wstrb_a [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int unsigned next_idx(input int unsigned idx, input logic [1:0] burst);
    return (burst == 2'b00) ? idx : (idx + 1) % MEM_WORDS;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wready"}, 32'(WREADY), 0);
    check({tag, "_bvalid"}, 32'(BVALID), 0);
    check({tag, "_rvalid"}, 32'(RVALID), 0);
    check({tag, "_rlast"},  32'(RLAST),  0);
  endtask

  // Write burst; WLAST is driven on beat wlast_at. reset_at >= 0 pulses ARESET on that beat.
  task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [7:0] id, input int wlast_at, input int reset_at);
    int unsigned idx;
    bit          err;
    int          n;
    idx = addr[AW+1:2];
    err = 1'b0;
    @(negedge ACLK);
    AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = 4'(len); AWBURST = burst; AWSIZE = 3'd2;
    n = 0;
    while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
    check("aw_ready", 32'(AWREADY), 1);
    @(posedge ACLK);
    @(negedge ACLK);
    AWVALID = 1'b0;
    check("aw_ready_busy", 32'(AWREADY), 0);
    for (int b = 0; b <= len; b++) begin
      WVALID = 1'b1; WDATA = wdata_a[b]; WSTRB = wstrb_a[b]; WLAST = (b == wlast_at);
      if (b == reset_at) begin
        ARESET = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        check("wrst_awready", 32'(AWREADY), 0);
        check("wrst_arready", 32'(ARREADY), 0);
        check_idle_outputs("wrst");
        ARESET = 1'b0; WVALID = 1'b0; WLAST = 1'b0;
        #1;
        check("wrst_awready_rel", 32'(AWREADY), 1);
        check("wrst_arready_rel", 32'(ARREADY), 1);
        check("wrst_wready_rel",  32'(WREADY),  0);
        return;
      end
      check("w_ready", 32'(WREADY), 1);
      @(posedge ACLK);
      for (int unsigned i = 0; i < 4; i++)
        if (wstrb_a[b][i]) ref_mem[idx][8*i +: 8] = wdata_a[b][8*i +: 8];
      if ((b == wlast_at) != (b == len)) err = 1'b1;
      idx = next_idx(idx, burst);
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    check("w_ready_done", 32'(WREADY), 0);
    repeat ($urandom_range(0, 2)) begin
      check("b_valid_hold", 32'(BVALID), 1);
      @(negedge ACLK);
    end
    check("b_valid", 32'(BVALID), 1);
    check("b_id",    32'(BID), 32'(id));
    check("b_resp",  32'(BRESP), err ? 32'd2 : 32'd0);
    BREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    BREADY = 1'b0;
    check("b_valid_done", 32'(BVALID), 0);
    check("aw_ready_after_b", 32'(AWREADY), 1);
  endtask

  // mode 0: RREADY always 1; mode 1: pattern 1,0,0 repeating; mode 2: random.
  task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [7:0] id, input int mode, input int reset_at);
    int unsigned idx;
    int          n;
    int          b;
    int          p;
    idx = addr[AW+1:2];
    @(negedge ACLK);
    ARVALID = 1'b1; ARID = id; ARADDR = addr; ARLEN = 4'(len); ARBURST = burst; ARSIZE = 3'd2;
    n = 0;
    while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
    check("ar_ready", 32'(ARREADY), 1);
    @(posedge ACLK);
    @(negedge ACLK);
    ARVALID = 1'b0;
    check("ar_ready_busy", 32'(ARREADY), 0);
    b = 0; p = 0; n = 0;
    while (b <= len && n < 200) begin
      check("r_valid", 32'(RVALID), 1);
      check("r_data",  RDATA, ref_mem[idx]);
      check("r_last",  32'(RLAST), 32'(b == len));
      check("r_id",    32'(RID), 32'(id));
      check("r_resp",  32'(RRESP), 0);
      if (b == reset_at) begin
        ARESET = 1'b1; RREADY = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        check("rrst_arready", 32'(ARREADY), 0);
        check("rrst_awready", 32'(AWREADY), 0);
        check("rrst_rdata",   RDATA, 0);
        check("rrst_rid",     32'(RID), 0);
        check_idle_outputs("rrst");
        ARESET = 1'b0;
        #1;
        check("rrst_arready_rel", 32'(ARREADY), 1);
        check("rrst_rvalid_rel",  32'(RVALID), 0);
        return;
      end
      case (mode)
        0:       RREADY = 1'b1;
        1:       RREADY = (p % 3 == 0);
        default: RREADY = 1'($urandom_range(0, 1));
      endcase
      p++;
      @(posedge ACLK);
      if (RREADY) begin
        b++;
        idx = next_idx(idx, burst);
      end
      n++;
      @(negedge ACLK);
    end
    RREADY = 1'b0;
    check("r_beats", 32'(b), 32'(len + 1));
    check("r_valid_done", 32'(RVALID), 0);
    check("ar_ready_after_r", 32'(ARREADY), 1);
  endtask

  task automatic fill(input int len, input logic [31:0] base, input bit rnd);
    for (int i = 0; i <= len; i++) begin
      wdata_a[i] = rnd ? $urandom : base + 32'(i);
      wstrb_a[i] = 4'hF;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    RREADY = 1'b0;
    repeat (3) @(negedge ACLK);
    check("rst_awready", 32'(AWREADY), 0);
    check("rst_arready", 32'(ARREADY), 0);
    check("rst_bid",     32'(BID), 0);
    check("rst_bresp",   32'(BRESP), 0);
    check("rst_rid",     32'(RID), 0);
    check("rst_rdata",   RDATA, 0);
    check("rst_rresp",   32'(RRESP), 0);
    check_idle_outputs("rst");
    ARESET = 1'b0;
    #1;
    check("rel_awready", 32'(AWREADY), 1);
    check("rel_arready", 32'(ARREADY), 1);

    // Single-beat write and readback.
    wdata_a[0] = 32'hDEADBEEF; wstrb_a[0] = 4'hF;
    axi_write(32'h10, 0, 2'b01, 8'h5A, 0, -1);
    axi_read(32'h10, 0, 2'b01, 8'h33, 0, -1);

    // Strobed INCR burst over a preset region.
    fill(3, 32'hFFFFFFFF, 1'b0);
    for (int i = 0; i < 4; i++) wdata_a[i] = 32'hFFFFFFFF;
    axi_write(32'h100, 3, 2'b01, 8'h01, 3, -1);
    fill(3, 32'd1, 1'b0);
    wstrb_a[2] = 4'h3;
    axi_write(32'h100, 3, 2'b01, 8'h02, 3, -1);
    axi_read(32'h100, 3, 2'b01, 8'h03, 0, -1);

    // Early WLAST: all beats still taken, SLVERR returned.
    fill(2, 32'hA000_0000, 1'b0);
    axi_write(32'h200, 2, 2'b01, 8'h44, 1, -1);
    axi_read(32'h200, 2, 2'b10, 8'h45, 0, -1);

    // Eight-beat read with stalls.
    fill(7, 32'h0, 1'b1);
    axi_write(32'h300, 7, 2'b01, 8'h10, 7, -1);
    axi_read(32'h300, 7, 2'b01, 8'h11, 1, -1);

    // Index wrap at top of memory, and FIXED burst into one word.
    fill(1, 32'h0, 1'b1);
    axi_write(32'((MEM_WORDS - 1) * 4), 1, 2'b01, 8'h20, 1, -1);
    axi_read(32'((MEM_WORDS - 1) * 4), 1, 2'b01, 8'h21, 0, -1);
    axi_read(32'h0, 0, 2'b01, 8'h22, 0, -1);
    fill(3, 32'h0, 1'b1);
    axi_write(32'h400, 3, 2'b00, 8'h23, 3, -1);
    axi_read(32'h400, 0, 2'b01, 8'h24, 0, -1);
    axi_read(32'h400, 3, 2'b00, 8'h25, 2, -1);

    // Randomized bursts: full-strobe preset, random-strobe overwrite, random-stall readback.
    for (int t = 0; t < 12; t++) begin
      logic [31:0] a;
      int          l;
      logic [1:0]  bt;
      a  = $urandom;
      l  = $urandom_range(0, 15);
      bt = 2'($urandom_range(0, 2));
      fill(15, 32'h0, 1'b1);
      axi_write(a, l, 2'b01, 8'($urandom), l, -1);
      fill(15, 32'h0, 1'b1);
      for (int i = 0; i < 16; i++) wstrb_a[i] = 4'($urandom);
      axi_write(a, l, bt, 8'($urandom), l, -1);
      axi_read(a, l, bt, 8'($urandom), 2, -1);
    end

    // Reset during write beat 1 and during read beat 2.
    fill(3, 32'h5555_0000, 1'b0);
    axi_write(32'h500, 3, 2'b01, 8'h30, 3, -1);
    fill(3, 32'h6666_0000, 1'b0);
    axi_write(32'h500, 3, 2'b01, 8'h31, 3, 1);
    axi_read(32'h500, 3, 2'b01, 8'h32, 0, -1);
    axi_read(32'h500, 3, 2'b01, 8'h33, 0, 2);
    axi_read(32'h500, 3, 2'b01, 8'h34, 2, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI3 responder with an internal word-addressed memory, attached to one slave port (S0 or S1) of the two-master AXI interconnect. It accepts write bursts on AW/W, answers them on B, and serves read bursts on AR/R. Reads and writes run as independent state machines. It is the slave-side endpoint used to bring up and verify the interconnect's muxes, decoders and arbiters.

## Interface
- MEM_WORDS, 1024: memory depth in 32-bit words; power of two; AW = log2(MEM_WORDS).
- IDS_BITS, `AXI_IDS_BITS (8): slave-side ID width (master ID plus interconnect-appended master index).
- ACLK  in  1  clock; all logic rising-edge.
- ARESET  in  1  synchronous, active-high reset.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  IDS_BITS/32/4/3/2/1  write address channel.
- AWREADY  out  1  write address accept.
- WDATA/WSTRB/WLAST/WVALID  in  32/4/1/1  write data channel.
- WREADY  out  1  write data accept.
- BID/BRESP/BVALID  out  IDS_BITS/2/1  write response; BREADY  in  1.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  IDS_BITS/32/4/3/2/1  read address channel.
- ARREADY  out  1  read address accept.
- RID/RDATA/RRESP/RLAST/RVALID  out  IDS_BITS/32/2/1/1  read data channel; RREADY  in  1.

## Operation
- Word index = ADDR[AW+1:2]; upper and lower address bits ignored; index wraps modulo MEM_WORDS.
- AxSIZE ignored (always 4-byte beats). AxBURST: 2'b00 FIXED holds index; 2'b01 INCR and 2'b10 WRAP both add 1 per beat.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY=1; on AWVALID&AWREADY latch AWID, index, AWLEN, AWBURST; clear beat count and error flag; go W_DATA.
  - W_DATA: WREADY=1; each WVALID&WREADY writes mem[index] byte lanes where WSTRB[i]=1, advances index per burst type, increments count.
  - Burst ends on the beat where count==AWLEN, regardless of WLAST; go W_RESP.
  - Error flag set if on any beat WLAST != (count==AWLEN).
  - W_RESP: BVALID=1, BID=latched ID, BRESP=2'b10 (SLVERR) if error flag else 2'b00; on BREADY go W_IDLE.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: ARREADY=1; on handshake latch ARID, ARLEN, ARBURST, RDATA<=mem[index0], count=0; go R_DATA.
  - R_DATA: RVALID=1, RID=latched ID, RRESP=2'b00, RLAST=(count==ARLEN); RDATA/RLAST stable while RREADY=0.
  - RVALID&RREADY with RLAST=0: advance index, RDATA<=mem[next index], count+1.
  - RVALID&RREADY with RLAST=1: go R_IDLE.
- Same-cycle write and read-load of one word: read returns old contents; write completes.
- Memory contents are not cleared by reset.

## Timing
- While ARESET=1 and the cycle after: FSMs in idle; AWREADY=ARREADY=0 during reset, 1 the first cycle ARESET=0. WREADY, BVALID, RVALID, RLAST=0; BID, BRESP, RID, RDATA, RRESP=0.
- AW handshake at edge T -> WREADY=1 from T+1; first beat can be accepted at T+1.
- Last W beat at edge T -> BVALID=1 from T+1; AWREADY returns the cycle after the B handshake.
- AR handshake at edge T -> RVALID=1 with beat 0 from T+1; one beat per cycle with RREADY held 1.
- Back-to-back bursts on a channel insert one idle cycle (ready) between them.
- AWREADY=0 outside W_IDLE and ARREADY=0 outside R_IDLE; no outstanding-transaction queuing.
- Valids, once asserted, stay high until handshake; payload constant meanwhile.
- ARESET asserted mid-burst: next edge both FSMs idle, all valids/readies per reset values; partial write beats already committed remain in memory.

## Test plan
- Single write AWADDR=0x10, AWLEN=0, WDATA=0xDEADBEEF, WSTRB=4'hF, WLAST=1 -> BVALID one cycle after W beat, BRESP=0, BID=AWID; read ARADDR=0x10 -> RDATA=0xDEADBEEF, RLAST=1.
- INCR write AWADDR=0x100, AWLEN=3, data 1..4, WSTRB=4'h3 on beat 2 over preset 0xFFFFFFFF word -> read back 1, 2, 0xFFFF0003, 4 with RLAST only on beat 4.
- WLAST asserted on beat 1 of AWLEN=2 burst -> three beats still accepted, BRESP=2'b10.
- Read AWLEN=7 burst with RREADY toggling 1,0,0,1… -> RDATA/RLAST held during stalls, 8 beats in order, ARREADY high one cycle after last beat.
- Address wrap: INCR write at word MEM_WORDS-1, LEN=1 -> second beat lands at word 0; FIXED burst LEN=3 -> only last data in target word.
- ARESET pulsed during R_DATA beat 2 and W_DATA beat 1 -> next cycle RVALID=WREADY=0, readies 1 after release, beat 0 write persists.
